// File: rtl/result_unload_pkg.sv
// Shared definitions for the result unload path: default geometry, byte
// derivation helpers and the unload FSM state encoding.
package result_unload_pkg;

    localparam int NUM_WORDS_DEF = 16;
    localparam int WORD_W_DEF    = 18;
    localparam int ADDR_W_DEF    = 4;

    // Bytes needed to carry one result word, rounding partial bytes up.
    function automatic int bytes_per_word(input int word_w);
        return (word_w + 7) / 8;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } unload_state_t;

endpackage

// File: rtl/result_unload_if.sv
// Bundle between the unload block, the result memory read port and the
// host-facing byte stream.
interface result_unload_if #(
    parameter int WORD_W = result_unload_pkg::WORD_W_DEF,
    parameter int ADDR_W = result_unload_pkg::ADDR_W_DEF
);
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rd_data;
    logic [7:0]        data_out;
    logic              valid_out;
    logic              ready_in;
    logic              busy;
    logic              done;

    // Byte stream: a byte transfers on a rising edge where valid_out && ready_in;
    // once raised, valid_out and data_out stay stable until that transfer.
    modport master (
        input  start, mem_rd_data, ready_in,
        output mem_rd_en, mem_addr, data_out, valid_out, busy, done
    );

    modport slave (
        output start, mem_rd_data, ready_in,
        input  mem_rd_en, mem_addr, data_out, valid_out, busy, done
    );

endinterface

// File: rtl/result_unload_byte_serializer.sv
// Holds one zero-extended result word and emits it MSB byte first on a
// valid/ready stream; reports the final byte so the FSM can move on.
module result_unload_byte_serializer
    import result_unload_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              ready_in,
    output logic [7:0]        data_out,
    output logic              valid_out,
    output logic              fire,
    output logic              last_byte
);
    localparam int BPW  = bytes_per_word(WORD_W);
    localparam int SR_W = 8 * BPW;
    localparam int BC_W = cnt_w(BPW);

    logic [SR_W-1:0] sr;
    logic [BC_W-1:0] byte_cnt;

    assign data_out  = sr[SR_W-1 -: 8];
    assign fire      = valid_out && ready_in;
    assign last_byte = (byte_cnt == BC_W'(BPW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            byte_cnt  <= '0;
            valid_out <= 1'b0;
        end else if (load) begin
            sr        <= SR_W'(word);
            byte_cnt  <= '0;
            valid_out <= 1'b1;
        end else if (fire) begin
            // The last byte stays on data_out after the transfer; only valid drops.
            if (last_byte) begin
                byte_cnt  <= '0;
                valid_out <= 1'b0;
            end else begin
                sr       <= sr << 8;
                byte_cnt <= byte_cnt + BC_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_unload.sv
// Unloads NUM_WORDS results from the synchronous result memory after finish
// and streams them to the host one byte at a time, pulsing done at the end.
module result_unload
    import result_unload_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    result_unload_if.master bus,
    output unload_state_t  state_dbg
);
    unload_state_t     state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              fire;
    logic              last_byte;
    logic [7:0]        ser_data;
    logic              ser_valid;

    result_unload_byte_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .word      (bus.mem_rd_data),
        .ready_in  (bus.ready_in),
        .data_out  (ser_data),
        .valid_out (ser_valid),
        .fire      (fire),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Outputs are registered, so each read strobe is set up on the edge that enters FETCH.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_FETCH;
                    busy_d      = 1'b1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = word_cnt_q;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (fire && last_byte) begin
                    if (word_cnt_q == ADDR_W'(NUM_WORDS - 1)) begin
                        state_d    = ST_DONE;
                        word_cnt_d = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d     = ST_FETCH;
                        word_cnt_d  = word_cnt_q + ADDR_W'(1);
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = word_cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.data_out  = ser_data;
    assign bus.valid_out = ser_valid;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign state_dbg     = state_q;

endmodule
